// File: rtl/tl_ul_edge_buffer.sv
// Two-channel TileLink-UL edge buffer: per-channel FIFOs plus an outstanding-request limiter.
// Optional build macro TL_BUFFER_FLOW_EN makes each empty FIFO flow-through (zero latency).

module tl_ul_edge_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             in_bits,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_bits,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             empty, wr_en, rd_en;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    count = wr_ptr_q - rd_ptr_q;
`ifdef TL_BUFFER_FLOW_EN
    // Bypass keys off the accepted push so an unaccepted beat never leaks downstream.
    out_valid = !empty || push;
    out_bits  = empty ? in_bits : mem_q[rd_idx];
    wr_en     = push && !(empty && out_ready);
    rd_en     = out_ready && !empty;
`else
    out_valid = !empty;
    out_bits  = mem_q[rd_idx];
    wr_en     = push;
    rd_en     = out_ready && !empty;
`endif
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_idx] = in_bits;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module tl_ul_edge_buffer #(
  parameter int unsigned SRC_W        = 4,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_a_valid,
  output logic                              in_a_ready,
  input  logic [76+SRC_W-1:0]               in_a_bits,
  output logic                              out_a_valid,
  input  logic                              out_a_ready,
  output logic [76+SRC_W-1:0]               out_a_bits,
  input  logic                              in_d_valid,
  output logic                              in_d_ready,
  input  logic [42+SRC_W-1:0]               in_d_bits,
  output logic                              out_d_valid,
  input  logic                              out_d_ready,
  output logic [42+SRC_W-1:0]               out_d_bits,
  output logic [$clog2(DEPTH):0]            a_count,
  output logic [$clog2(DEPTH):0]            d_count,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              d_orphan
);
  localparam int unsigned A_W   = 76 + SRC_W;
  localparam int unsigned D_W   = 42 + SRC_W;
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             d_orphan_q, d_orphan_d;
  logic             a_full, d_full, a_push, d_push;

  assign in_a_ready = !a_full && (inflight_q < MAX_CNT);
  assign in_d_ready = !d_full;
  assign a_push     = in_a_valid && in_a_ready;
  assign d_push     = in_d_valid && in_d_ready;
  assign inflight   = inflight_q;
  assign d_orphan   = d_orphan_q;

  tl_ul_edge_fifo #(.W(A_W), .DEPTH(DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (a_push),
    .in_bits   (in_a_bits),
    .out_ready (out_a_ready),
    .out_valid (out_a_valid),
    .out_bits  (out_a_bits),
    .full      (a_full),
    .count     (a_count)
  );

  tl_ul_edge_fifo #(.W(D_W), .DEPTH(DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (d_push),
    .in_bits   (in_d_bits),
    .out_ready (out_d_ready),
    .out_valid (out_d_valid),
    .out_bits  (out_d_bits),
    .full      (d_full),
    .count     (d_count)
  );

  // A response with nothing outstanding is flagged rather than underflowing the counter.
  always_comb begin
    inflight_d = inflight_q;
    d_orphan_d = d_orphan_q;
    if (a_push) inflight_d = inflight_d + CNT_W'(1);
    if (d_push) begin
      if (inflight_q != '0) inflight_d = inflight_d - CNT_W'(1);
      else                  d_orphan_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      d_orphan_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      d_orphan_q <= d_orphan_d;
    end
  end
endmodule

// File: tb/tb_tl_ul_edge_buffer.sv
// Scoreboard bench for tl_ul_edge_buffer: channel data via queues, directed checks on readies/counters.

module tb_tl_ul_edge_buffer;
  localparam int unsigned SRC_W = 4;
  localparam int unsigned A_W   = 76 + SRC_W;
  localparam int unsigned D_W   = 42 + SRC_W;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_a_valid = 1'b0, in_a_ready;
  logic [A_W-1:0] in_a_bits = '0;
  logic           out_a_valid, out_a_ready = 1'b0;
  logic [A_W-1:0] out_a_bits;
  logic           in_d_valid = 1'b0, in_d_ready;
  logic [D_W-1:0] in_d_bits = '0;
  logic           out_d_valid, out_d_ready = 1'b0;
  logic [D_W-1:0] out_d_bits;
  logic [1:0]     a_count, d_count;
  logic [2:0]     inflight;
  logic           d_orphan;

  int n_checks = 0;
  int n_errors = 0;
  logic [A_W-1:0] a_exp[$];
  logic [D_W-1:0] d_exp[$];
  int unsigned d_seq = 0;

  tl_ul_edge_buffer #(.SRC_W(SRC_W), .DEPTH(2), .MAX_INFLIGHT(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_a_valid  (in_a_valid),
    .in_a_ready  (in_a_ready),
    .in_a_bits   (in_a_bits),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_a_bits  (out_a_bits),
    .in_d_valid  (in_d_valid),
    .in_d_ready  (in_d_ready),
    .in_d_bits   (in_d_bits),
    .out_d_valid (out_d_valid),
    .out_d_ready (out_d_ready),
    .out_d_bits  (out_d_bits),
    .a_count     (a_count),
    .d_count     (d_count),
    .inflight    (inflight),
    .d_orphan    (d_orphan)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [A_W-1:0] mk_a(input logic [SRC_W-1:0] src, input logic [31:0] addr,
                                          input logic [31:0] data);
    return {3'd0, 3'd0, 2'd2, src, addr, 4'hF, data};
  endfunction

  function automatic logic [D_W-1:0] mk_d(input logic [SRC_W-1:0] src, input logic [31:0] data);
    return {3'd1, 2'd0, 2'd2, src, 1'b0, 1'b0, data, 1'b0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic [A_W-1:0] bits);
    logic fired = 1'b0;
    in_a_valid = 1'b1;
    in_a_bits  = bits;
    for (int i = 0; i < 50 && !fired; i++) begin
      fired = in_a_ready;
      step();
    end
    if (!fired) check("a_accept_timeout", 0, 1);
    in_a_valid = 1'b0;
  endtask

  task automatic send_d();
    logic fired = 1'b0;
    d_seq++;
    in_d_valid = 1'b1;
    in_d_bits  = mk_d(SRC_W'(d_seq), 32'hD000_0000 + d_seq);
    for (int i = 0; i < 50 && !fired; i++) begin
      fired = in_d_ready;
      step();
    end
    if (!fired) check("d_accept_timeout", 0, 1);
    in_d_valid = 1'b0;
  endtask

  // Scoreboard: record accepted inputs, compare every output beat in order.
  always @(negedge clock) begin
    if (reset_n) begin
      if (in_a_valid && in_a_ready) a_exp.push_back(in_a_bits);
      if (in_d_valid && in_d_ready) d_exp.push_back(in_d_bits);
      if (out_a_valid && out_a_ready) begin
        if (a_exp.size() == 0) check("a_unexpected_beat", 1, 0);
        else check("a_beat", out_a_bits, a_exp.pop_front());
      end
      if (out_d_valid && out_d_ready) begin
        if (d_exp.size() == 0) check("d_unexpected_beat", 1, 0);
        else check("d_beat", out_d_bits, d_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=1 exp=0");
    $fatal(1);
  end

  initial begin
    logic [A_W-1:0] a0;
    a0 = mk_a(4'd3, 32'h8000_0000, 32'hDEAD_BEEF);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    check("rst_out_a_valid", out_a_valid, 0);
    check("rst_out_d_valid", out_d_valid, 0);
    check("rst_in_a_ready",  in_a_ready, 1);
    check("rst_in_d_ready",  in_d_ready, 1);
    check("rst_a_count",     a_count, 0);
    check("rst_d_count",     d_count, 0);
    check("rst_inflight",    inflight, 0);
    check("rst_d_orphan",    d_orphan, 0);

    // Single A held while slave stalls
    send_a(a0);
    check("a1_valid", out_a_valid, 1);
    check("a1_bits", out_a_bits, a0);
    check("a1_count", a_count, 1);
    check("a1_inflight", inflight, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("a1_hold_valid", out_a_valid, 1);
      check("a1_hold_bits", out_a_bits, a0);
    end
    out_a_ready = 1'b1;
    step();
    out_a_ready = 1'b0;
    check("a1_drained", a_count, 0);

    // Fill the A FIFO, then drain in order
    send_a(mk_a(4'd0, 32'h1000_0000, 32'h0000_0001));
    send_a(mk_a(4'd1, 32'h1000_0004, 32'h0000_0002));
    check("full_in_a_ready", in_a_ready, 0);
    check("full_a_count", a_count, 2);
    out_a_ready = 1'b1;
    step();
    check("pop1_in_a_ready", in_a_ready, 1);
    check("pop1_a_count", a_count, 1);
    step();
    out_a_ready = 1'b0;
    check("pop2_a_count", a_count, 0);
    check("pop2_inflight", inflight, 3);

    // Retire everything outstanding
    out_d_ready = 1'b1;
    repeat (3) send_d();
    step();
    check("retire_inflight", inflight, 0);
    check("retire_orphan", d_orphan, 0);

    // Inflight limit stalls A even with an empty FIFO
    out_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_a(mk_a(SRC_W'(i), 32'h2000_0000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i)));
    step();
    check("lim_inflight", inflight, 4);
    check("lim_in_a_ready", in_a_ready, 0);
    check("lim_a_count", a_count, 0);
    send_d();
    check("lim_release_inflight", inflight, 3);
    check("lim_release_ready", in_a_ready, 1);
    repeat (3) send_d();
    step();
    check("zero_inflight", inflight, 0);

    // Orphan response: flagged, not counted, still forwarded
    send_d();
    check("orphan_set", d_orphan, 1);
    check("orphan_inflight", inflight, 0);
    repeat (3) step();
    check("orphan_sticky", d_orphan, 1);

    // Concurrent A and D accept leave inflight unchanged
    send_a(mk_a(4'd7, 32'h3000_0000, 32'h1111_1111));
    send_a(mk_a(4'd8, 32'h3000_0004, 32'h2222_2222));
    step();
    check("both_pre_inflight", inflight, 2);
    check("both_pre_ready", {in_a_ready, in_d_ready}, 2'b11);
    in_a_valid = 1'b1;
    in_a_bits  = mk_a(4'd9, 32'h3000_0008, 32'h3333_3333);
    in_d_valid = 1'b1;
    in_d_bits  = mk_d(4'd9, 32'h4444_4444);
    step();
    in_a_valid = 1'b0;
    in_d_valid = 1'b0;
    check("both_inflight", inflight, 2);
    repeat (3) step();

`ifdef TL_BUFFER_FLOW_EN
    // Empty FIFO with a ready slave passes the beat straight through
    check("flow_pre_count", a_count, 0);
    in_a_valid = 1'b1;
    in_a_bits  = mk_a(4'd5, 32'h5000_0000, 32'h5555_5555);
    #1;
    check("flow_valid", out_a_valid, 1);
    check("flow_bits", out_a_bits, mk_a(4'd5, 32'h5000_0000, 32'h5555_5555));
    check("flow_count", a_count, 0);
    step();
    in_a_valid = 1'b0;
    check("flow_post_count", a_count, 0);
`endif

    out_a_ready = 1'b1;
    out_d_ready = 1'b1;
    repeat (4) step();
    check("a_sb_empty", a_exp.size(), 0);
    check("d_sb_empty", d_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
